// File: rtl/wb_mem_arbiter_pkg.sv
// wb_mem_arbiter_pkg: shared Wishbone arbiter types and default bus widths
package wb_mem_arbiter_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT_ACK} arb_state_t;

    localparam int WB_DW = 32;
    localparam int WB_AW = 32;

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// wb_mem_arbiter_if: N-master to one-slave pipelined Wishbone bundle
interface wb_mem_arbiter_if import wb_mem_arbiter_pkg::*; #(
    parameter int N_MST = 3,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
);
    logic [N_MST-1:0]        m_cyc;
    logic [N_MST-1:0]        m_stb;
    logic [N_MST-1:0]        m_we;
    logic [N_MST*DW/8-1:0]   m_be;
    logic [N_MST*AW-1:0]     m_addr;
    logic [N_MST*DW-1:0]     m_wdata;
    logic [DW-1:0]           m_rdata;
    logic [N_MST-1:0]        m_ack;
    logic [N_MST-1:0]        m_err;
    logic [N_MST-1:0]        m_stall;
    logic                    s_cyc;
    logic                    s_stb;
    logic                    s_we;
    logic [DW/8-1:0]         s_be;
    logic [AW-1:0]           s_addr;
    logic [DW-1:0]           s_wdata;
    logic [DW-1:0]           s_rdata;
    logic                    s_ack;
    logic                    s_stall;

    // environment side: the masters plus the shared memory slave
    modport master (
        output m_cyc, m_stb, m_we, m_be, m_addr, m_wdata, s_rdata, s_ack, s_stall,
        input  m_rdata, m_ack, m_err, m_stall, s_cyc, s_stb, s_we, s_be, s_addr, s_wdata
    );

    // arbiter side
    modport slave (
        input  m_cyc, m_stb, m_we, m_be, m_addr, m_wdata, s_rdata, s_ack, s_stall,
        output m_rdata, m_ack, m_err, m_stall, s_cyc, s_stb, s_we, s_be, s_addr, s_wdata
    );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first requester after ptr wins
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    // scan from farthest to nearest so the nearest requester after ptr is kept
    always_comb begin
        gnt = '0;
        for (int k = N; k >= 1; k--)
            for (int i = 0; i < N; i++)
                if (i == (int'(ptr) + k) % N && req[i]) gnt = N'(1) << i;
    end

    assign valid = |req;

endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: round-robin share of one pipelined Wishbone slave with hang watchdog
module wb_mem_arbiter import wb_mem_arbiter_pkg::*; #(
    parameter int N_MST   = 3,
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    wb_mem_arbiter_if.slave   bus,
    output logic [N_MST-1:0]  grant,
    output logic              busy
);

    localparam int PW = N_MST > 1 ? $clog2(N_MST) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = DW / 8;

    arb_state_t      state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gi;
    logic [TW-1:0]   tmo_cnt;
    logic [N_MST-1:0] req;
    logic [N_MST-1:0] pick;
    logic            pick_valid;
    logic            own_cyc;
    logic            in_req;
    logic            done;
    logic            tmo;

    assign req = bus.m_cyc & bus.m_stb;

    rr_pick #(.N(N_MST), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .gnt   (pick),
        .valid (pick_valid)
    );

    // owner index from the one-hot grant, used for all muxing
    always_comb begin
        gi = '0;
        for (int i = 0; i < N_MST; i++)
            if (grant[i]) gi = PW'(i);
    end

    // a stalled strobe has not been accepted, so an ack then belongs to nobody
    assign own_cyc = state != ARB_IDLE && bus.m_cyc[gi];
    assign in_req  = state == ARB_REQ;
    assign done    = own_cyc && bus.s_ack && !(in_req && bus.s_stall);
    assign tmo     = own_cyc && !done && tmo_cnt == TW'(TIMEOUT);

    assign bus.s_cyc   = own_cyc && !tmo;
    assign bus.s_stb   = in_req && own_cyc && !tmo;
    assign bus.s_we    = bus.m_we[gi];
    assign bus.s_be    = bus.m_be[gi*BW +: BW];
    assign bus.s_addr  = bus.m_addr[gi*AW +: AW];
    assign bus.s_wdata = bus.m_wdata[gi*DW +: DW];
    assign bus.m_ack   = done ? grant : '0;
    assign bus.m_err   = tmo ? grant : '0;
    assign bus.m_rdata = done ? bus.s_rdata : '0;
    assign bus.m_stall = in_req ? ~(grant & {N_MST{~bus.s_stall}}) : '1;

    // arbitration FSM: grant in IDLE, release on completion, abort or watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB_IDLE;
            grant   <= '0;
            rr_ptr  <= PW'(N_MST - 1);
            tmo_cnt <= '0;
            busy    <= 1'b0;
        end else if (state == ARB_IDLE) begin
            if (pick_valid) begin
                state   <= ARB_REQ;
                grant   <= pick;
                tmo_cnt <= '0;
                busy    <= 1'b1;
            end
        end else if (!own_cyc || done || tmo) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            rr_ptr <= gi;
            busy   <= 1'b0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (in_req && !bus.s_stall) state <= ARB_WAIT_ACK;
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: vector table, directed corner sequences and random run against a transaction model
module tb_wb_mem_arbiter;
    import wb_mem_arbiter_pkg::*;

    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] grant;
    logic         busy;

    wb_mem_arbiter_if #(.N_MST(N), .AW(AW), .DW(DW)) bus ();

    wb_mem_arbiter #(.N_MST(N), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         rst;
        logic [N-1:0] cyc;
        logic         s_stall;
        logic         s_ack;
        logic [N-1:0] grant;
        logic         s_cyc;
        logic         s_stb;
        logic         busy;
        logic [N-1:0] stall;
        logic [N-1:0] ack;
    } vec_t;

    vec_t tbl [16];

    // transaction-level model: who owns the slave, whether the strobe was taken, how long it has waited
    int           owner;
    int           last;
    int           age;
    bit           accepted;
    bit           alive;
    bit           hit;
    bit           to;
    logic [N-1:0] e_grant, e_stall, e_ack, e_err;
    logic         e_scyc, e_sstb;
    logic [DW-1:0] e_rdata;
    int           k_wait;

    function automatic vec_t v(input logic r, input logic [N-1:0] c, input logic st, input logic ak,
                               input logic [N-1:0] g, input logic sc, input logic sb, input logic b,
                               input logic [N-1:0] sl, input logic [N-1:0] a);
        vec_t x;
        x.rst = r; x.cyc = c; x.s_stall = st; x.s_ack = ak;
        x.grant = g; x.s_cyc = sc; x.s_stb = sb; x.busy = b; x.stall = sl; x.ack = a;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive(input logic [N-1:0] cyc, input logic st, input logic ak);
        bus.m_cyc   = cyc;
        bus.m_stb   = cyc;
        bus.s_stall = st;
        bus.s_ack   = ak;
    endtask

    initial begin
        bus.m_we = '0; bus.m_be = '0; bus.m_addr = '0; bus.m_wdata = '0; bus.s_rdata = '0;
        drive(3'b111, 1'b0, 1'b0);

        // reset with all strobes held, then three round-robin transfers and one more for m0
        tbl[0]  = v(1, 3'b111, 0, 0, 3'b000, 0, 0, 0, 3'b111, 3'b000);
        tbl[1]  = v(1, 3'b111, 0, 0, 3'b000, 0, 0, 0, 3'b111, 3'b000);
        tbl[2]  = v(0, 3'b111, 0, 0, 3'b000, 0, 0, 0, 3'b111, 3'b000);
        tbl[3]  = v(0, 3'b111, 0, 0, 3'b001, 1, 1, 1, 3'b110, 3'b000);
        tbl[4]  = v(0, 3'b111, 0, 1, 3'b001, 1, 0, 1, 3'b111, 3'b001);
        tbl[5]  = v(0, 3'b111, 0, 0, 3'b000, 0, 0, 0, 3'b111, 3'b000);
        tbl[6]  = v(0, 3'b111, 0, 0, 3'b010, 1, 1, 1, 3'b101, 3'b000);
        tbl[7]  = v(0, 3'b111, 0, 1, 3'b010, 1, 0, 1, 3'b111, 3'b010);
        tbl[8]  = v(0, 3'b111, 0, 0, 3'b000, 0, 0, 0, 3'b111, 3'b000);
        tbl[9]  = v(0, 3'b111, 0, 0, 3'b100, 1, 1, 1, 3'b011, 3'b000);
        tbl[10] = v(0, 3'b111, 0, 1, 3'b100, 1, 0, 1, 3'b111, 3'b100);
        tbl[11] = v(0, 3'b111, 0, 0, 3'b000, 0, 0, 0, 3'b111, 3'b000);
        tbl[12] = v(0, 3'b111, 0, 0, 3'b001, 1, 1, 1, 3'b110, 3'b000);
        tbl[13] = v(0, 3'b111, 0, 1, 3'b001, 1, 0, 1, 3'b111, 3'b001);
        tbl[14] = v(0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 3'b111, 3'b000);
        tbl[15] = v(0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 3'b111, 3'b000);

        for (int i = 0; i < 16; i++) begin
            tick();
            rst = tbl[i].rst;
            drive(tbl[i].cyc, tbl[i].s_stall, tbl[i].s_ack);
            bus.s_rdata = 32'h100 + i;
            settle();
            check($sformatf("tbl%0d_grant", i), grant, tbl[i].grant);
            check($sformatf("tbl%0d_bus", i), {busy, bus.s_cyc, bus.s_stb},
                  {tbl[i].busy, tbl[i].s_cyc, tbl[i].s_stb});
            check($sformatf("tbl%0d_stall", i), bus.m_stall, tbl[i].stall);
            check($sformatf("tbl%0d_ack", i), bus.m_ack, tbl[i].ack);
            check($sformatf("tbl%0d_err", i), bus.m_err, 3'b000);
            check($sformatf("tbl%0d_rdata", i), bus.m_rdata, |tbl[i].ack ? 32'h100 + i : 32'h0);
        end

        // m1 write held through three stall cycles
        tick();
        drive(3'b010, 1'b1, 1'b0);
        bus.m_we = 3'b010;
        bus.m_be[1*BW +: BW] = 4'b0011;
        bus.m_addr[1*AW +: AW] = 32'h100;
        bus.m_wdata[1*DW +: DW] = 32'hDEADBEEF;
        settle();
        check("wr_idle_grant", grant, 3'b000);
        for (int c = 0; c < 4; c++) begin
            tick();
            bus.s_stall = c < 3;
            settle();
            check($sformatf("wr%0d_req", c), {bus.s_stb, bus.s_we, bus.s_be, bus.s_addr}, {1'b1, 1'b1, 4'b0011, 32'h100});
            check($sformatf("wr%0d_wdata", c), bus.s_wdata, 32'hDEADBEEF);
            check($sformatf("wr%0d_stall", c), bus.m_stall, c < 3 ? 3'b111 : 3'b101);
            check($sformatf("wr%0d_ack", c), bus.m_ack, 3'b000);
        end
        tick();
        bus.s_ack = 1'b1;
        settle();
        check("wr_ack", bus.m_ack, 3'b010);
        check("wr_wait_bus", {bus.s_cyc, bus.s_stb}, 2'b10);
        tick();
        drive(3'b000, 1'b0, 1'b0);
        bus.m_we = '0;
        settle();
        check("wr_release", {grant, bus.m_ack}, 6'b000000);

        // hung slave: err 16 cycles after strobe rises, then m0 after one idle cycle
        tick();
        drive(3'b101, 1'b0, 1'b0);
        settle();
        check("tmo_idle_grant", grant, 3'b000);
        tick();
        settle();
        check("tmo_req", {grant, bus.s_stb}, {3'b100, 1'b1});
        for (k_wait = 1; k_wait <= 40; k_wait++) begin
            tick();
            settle();
            if (|bus.m_err) break;
        end
        check("tmo_delay", k_wait, TMO);
        check("tmo_err", {bus.m_err, bus.s_cyc, bus.m_ack}, {3'b100, 1'b0, 3'b000});
        tick();
        drive(3'b001, 1'b0, 1'b0);
        settle();
        check("tmo_gap", {grant, bus.m_err, busy}, {3'b000, 3'b000, 1'b0});
        tick();
        bus.s_ack = 1'b1;
        bus.s_rdata = 32'hCAFEF00D;
        settle();
        check("tmo_next_grant", grant, 3'b001);
        check("same_cycle_ack", bus.m_ack, 3'b001);
        check("same_cycle_rdata", bus.m_rdata, 32'hCAFEF00D);
        tick();
        drive(3'b000, 1'b0, 1'b0);
        settle();
        check("tmo_release", grant, 3'b000);

        // m2 aborts in WAIT_ACK, late stray ack must reach nobody
        tick();
        drive(3'b100, 1'b0, 1'b0);
        settle();
        tick();
        settle();
        check("abort_req", {grant, bus.s_stb}, {3'b100, 1'b1});
        tick();
        drive(3'b000, 1'b0, 1'b0);
        settle();
        check("abort_drop", {bus.s_cyc, bus.m_ack, bus.m_err}, 7'b0);
        tick();
        settle();
        check("abort_idle", grant, 3'b000);
        tick();
        drive(3'b001, 1'b0, 1'b1);
        bus.s_rdata = 32'h5555AAAA;
        settle();
        check("stray_ack", {grant, bus.m_ack}, 6'b000000);
        check("stray_rdata", bus.m_rdata, 32'h0);
        tick();
        drive(3'b001, 1'b1, 1'b0);
        settle();
        check("abort_next", {grant, bus.m_stall}, {3'b001, 3'b111});
        tick();
        bus.s_stall = 1'b0;
        settle();
        tick();
        bus.s_ack = 1'b1;
        bus.s_rdata = 32'h12345678;
        settle();
        check("abort_next_ack", bus.m_ack, 3'b001);
        check("abort_next_rdata", bus.m_rdata, 32'h12345678);
        tick();
        drive(3'b000, 1'b0, 1'b0);
        settle();

        // async reset in WAIT_ACK
        tick();
        drive(3'b010, 1'b0, 1'b0);
        settle();
        tick();
        settle();
        tick();
        settle();
        check("rst_wait", {grant, bus.s_cyc, bus.s_stb}, {3'b010, 1'b1, 1'b0});
        rst = 1'b1;
        drive(3'b111, 1'b0, 1'b1);
        #1;
        check("rst_async", {grant, bus.s_cyc, bus.m_ack, busy}, 8'b0);
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("rst_idle", {grant, busy}, 4'b0);
        tick();
        settle();
        check("rst_first_tie", grant, 3'b001);

        // random traffic against the model
        tick();
        rst = 1'b1;
        drive(3'b000, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        owner = -1; last = N - 1; age = 0; accepted = 1'b0;
        for (int t = 0; t < 800; t++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                bus.m_cyc[i] = $urandom_range(0, t < 400 ? 7 : 63) != 0;
                bus.m_stb[i] = bus.m_cyc[i] & ($urandom_range(0, 3) != 0);
            end
            bus.m_we    = N'($urandom);
            bus.m_be    = (N*BW)'($urandom);
            bus.m_addr  = {$urandom, $urandom, $urandom};
            bus.m_wdata = {$urandom, $urandom, $urandom};
            bus.s_stall = $urandom_range(0, 2) == 0;
            bus.s_ack   = t < 400 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 39) == 0;
            bus.s_rdata = $urandom;
            settle();
            e_grant = '0; e_stall = '1; e_ack = '0; e_err = '0; e_scyc = 1'b0; e_sstb = 1'b0; e_rdata = '0;
            alive = 1'b0; hit = 1'b0; to = 1'b0;
            if (owner >= 0) begin
                alive   = bus.m_cyc[owner];
                hit     = alive && bus.s_ack && (accepted || !bus.s_stall);
                to      = alive && !hit && age == TMO;
                e_grant = N'(1) << owner;
                e_scyc  = alive && !to;
                e_sstb  = alive && !accepted && !to;
                if (!accepted) e_stall[owner] = bus.s_stall;
                e_ack   = hit ? e_grant : '0;
                e_err   = to ? e_grant : '0;
                e_rdata = hit ? bus.s_rdata : '0;
            end
            check($sformatf("rnd%0d_ctl", t), {grant, busy, bus.s_cyc, bus.s_stb, bus.m_stall, bus.m_ack, bus.m_err},
                  {e_grant, owner >= 0, e_scyc, e_sstb, e_stall, e_ack, e_err});
            check($sformatf("rnd%0d_rdata", t), bus.m_rdata, e_rdata);
            if (e_sstb) begin
                check($sformatf("rnd%0d_req", t), {bus.s_we, bus.s_be, bus.s_addr},
                      {bus.m_we[owner], bus.m_be[owner*BW +: BW], bus.m_addr[owner*AW +: AW]});
                check($sformatf("rnd%0d_wdata", t), bus.s_wdata, bus.m_wdata[owner*DW +: DW]);
            end
            if (owner < 0) begin
                for (int k = 1; k <= N; k++)
                    if (owner < 0 && bus.m_cyc[(last + k) % N] && bus.m_stb[(last + k) % N]) owner = (last + k) % N;
                accepted = 1'b0;
                age = 0;
            end else if (!alive || hit || to) begin
                last = owner;
                owner = -1;
            end else begin
                age++;
                if (!bus.s_stall) accepted = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
